stopwatch_lap_ctrl: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/stopwatch_lap_ctrl_bcd_split.sv | 11 +
 rtl/stopwatch_lap_ctrl.sv | 138 +++++++++++++
 tb/tb_stopwatch_lap_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lab stopwatch sequencing controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } sw_state_e;

    localparam logic [3:0] ERR_DIGIT = 4'hB;
    localparam logic [6:0] CSEC_MAX  = 7'd99;

    typedef struct packed {
        logic [6:0] sec;
        logic [6:0] csec;
    } lap_rec_t;

endpackage

// File: rtl/stopwatch_lap_ctrl_bcd_split.sv
// Combinational split of a 0..99 value into BCD tens and ones digits.
module bcd_split (
    input  logic [6:0] value_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    assign tens_o = 4'(value_i / 7'd10);
    assign ones_o = 4'(value_i % 7'd10);

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch run/pause/done sequencer with centisecond counter, lap bank and
// registered 4-digit BCD display source arbitration.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MAX_SEC   = 20,
    parameter int LAP_DEPTH = 2
) (
    input  logic        clk15,
    input  logic        rst,
    input  logic        tick,
    input  logic        start_p,
    input  logic        record_p,
    input  logic        sel1,
    input  logic        sel2,
    output logic        running,
    output logic        done,
    output logic [1:0]  lap_cnt,
    output logic        lap_full,
    output logic [15:0] disp_bcd
);

    // The display always addresses lap 0 and lap 1, so the bank is at least two deep.
    localparam int BANK = (LAP_DEPTH < 2) ? 2 : LAP_DEPTH;

    sw_state_e   state_q;
    logic [6:0]  sec_q;
    logic [6:0]  csec_q;
    logic [1:0]  lap_cnt_q;
    lap_rec_t    laps_q [BANK];
    logic [15:0] disp_q;
    logic [15:0] disp_d;

    logic        lap_full_w;
    logic        record_ok;
    logic [6:0]  src_sec;
    logic [6:0]  src_csec;
    logic [3:0]  sec_tens, sec_ones, csec_tens, csec_ones;

    assign lap_full_w = (lap_cnt_q == 2'(LAP_DEPTH));
    assign record_ok  = record_p && !lap_full_w && (state_q == RUN || state_q == PAUSE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the lap bank is small and reset with the rest,
    // since a cleared bank must read back as 00:00.
    always_ff @(posedge clk15 or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sec_q     <= '0;
            csec_q    <= '0;
            lap_cnt_q <= '0;
            for (int i = 0; i < BANK; i++) laps_q[i] <= '0;
        end else begin
            // Record first: it sees the pre-tick count and the current state.
            if (record_ok) begin
                for (int i = 0; i < BANK; i++) begin
                    if (lap_cnt_q == 2'(i)) laps_q[i] <= '{sec: sec_q, csec: csec_q};
                end
                lap_cnt_q <= lap_cnt_q + 2'd1;
            end

            case (state_q)
                IDLE: begin
                    if (start_p) state_q <= RUN;
                end
                RUN: begin
                    if (start_p) state_q <= PAUSE;
                    if (tick) begin
                        if (csec_q == CSEC_MAX) begin
                            csec_q <= '0;
                            sec_q  <= sec_q + 7'd1;
                            // Terminal value overrides a simultaneous pause.
                            if (sec_q == 7'(MAX_SEC - 1)) state_q <= DONE;
                        end else begin
                            csec_q <= csec_q + 7'd1;
                        end
                    end
                end
                PAUSE: begin
                    if (start_p) state_q <= RUN;
                end
                DONE: begin
                    if (start_p) begin
                        state_q   <= IDLE;
                        sec_q     <= '0;
                        csec_q    <= '0;
                        lap_cnt_q <= '0;
                        for (int i = 0; i < BANK; i++) laps_q[i] <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign running  = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign lap_cnt  = lap_cnt_q;
    assign lap_full = lap_full_w;

    // NOTE: defaults first so no path through the mux leaves a latch.
    always_comb begin
        src_sec  = sec_q;
        src_csec = csec_q;
        if (sel1 && !running) begin
            src_sec  = laps_q[0].sec;
            src_csec = laps_q[0].csec;
        end else if (sel2 && !running) begin
            src_sec  = laps_q[1].sec;
            src_csec = laps_q[1].csec;
        end
    end

    bcd_split u_split_sec (
        .value_i (src_sec),
        .tens_o  (sec_tens),
        .ones_o  (sec_ones)
    );

    bcd_split u_split_csec (
        .value_i (src_csec),
        .tens_o  (csec_tens),
        .ones_o  (csec_ones)
    );

    always_comb begin
        disp_d = {sec_tens, sec_ones, csec_tens, csec_ones};
        if (sel1 && sel2) disp_d = {4{ERR_DIGIT}};
    end

    always_ff @(posedge clk15 or posedge rst) begin
        if (rst) disp_q <= '0;
        else     disp_q <= disp_d;
    end

    assign disp_bcd = disp_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed self-checking bench for stopwatch_lap_ctrl (MAX_SEC=20, LAP_DEPTH=2).
module tb_stopwatch_lap_ctrl;

    logic        clk15 = 1'b0;
    logic        rst;
    logic        tick, start_p, record_p, sel1, sel2;
    logic        running, done, lap_full;
    logic [1:0]  lap_cnt;
    logic [15:0] disp_bcd;

    int tests = 0;
    int fails = 0;

    stopwatch_lap_ctrl #(.MAX_SEC(20), .LAP_DEPTH(2)) dut (
        .clk15    (clk15),
        .rst      (rst),
        .tick     (tick),
        .start_p  (start_p),
        .record_p (record_p),
        .sel1     (sel1),
        .sel2     (sel2),
        .running  (running),
        .done     (done),
        .lap_cnt  (lap_cnt),
        .lap_full (lap_full),
        .disp_bcd (disp_bcd)
    );

    always #5 clk15 = ~clk15;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk15);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            @(negedge clk15);
            tick = 1'b0;
        end
    endtask

    task automatic pulse(input logic s, input logic r, input logic t);
        start_p  = s;
        record_p = r;
        tick     = t;
        @(negedge clk15);
        start_p  = 1'b0;
        record_p = 1'b0;
        tick     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_running"},  16'(running),  16'h0);
        check({tag, "_done"},     16'(done),     16'h0);
        check({tag, "_lap_cnt"},  16'(lap_cnt),  16'h0);
        check({tag, "_lap_full"}, 16'(lap_full), 16'h0);
        check({tag, "_disp"},     disp_bcd,      16'h0000);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; start_p = 1'b0; record_p = 1'b0; sel1 = 1'b0; sel2 = 1'b0;
        #3;
        check_reset_outputs("in_reset");
        idle(2);
        rst = 1'b0;
        idle(1);
        check_reset_outputs("after_reset");

        // Basic run to 01.50
        pulse(1, 0, 0);
        check("start_running", 16'(running), 16'h1);
        ticks(150);
        idle(1);
        check("run_150", disp_bcd, 16'h0150);
        check("run_150_running", 16'(running), 16'h1);

        // Terminal value 20:00
        ticks(1850);
        idle(1);
        check("terminal_disp", disp_bcd, 16'h2000);
        check("terminal_done", 16'(done), 16'h1);
        check("terminal_running", 16'(running), 16'h0);
        ticks(5);
        idle(1);
        check("done_extra_ticks", disp_bcd, 16'h2000);
        pulse(1, 0, 1);
        check("done_to_idle_done", 16'(done), 16'h0);
        check("done_to_idle_running", 16'(running), 16'h0);
        idle(1);
        check("done_to_idle_disp", disp_bcd, 16'h0000);

        // Laps at 03.25 and 07.10, third ignored
        pulse(1, 0, 0);
        ticks(325);
        pulse(0, 1, 0);
        check("lap1_cnt", 16'(lap_cnt), 16'h1);
        ticks(385);
        pulse(0, 1, 0);
        check("lap2_cnt", 16'(lap_cnt), 16'h2);
        check("lap2_full", 16'(lap_full), 16'h1);
        ticks(10);
        pulse(0, 1, 0);
        check("lap3_ignored", 16'(lap_cnt), 16'h2);
        sel1 = 1'b1;
        idle(1);
        check("sel1_running_live", disp_bcd, 16'h0720);
        sel1 = 1'b0;
        pulse(1, 0, 0);
        check("pause_running", 16'(running), 16'h0);
        sel1 = 1'b1;
        idle(1);
        check("pause_sel1_lap0", disp_bcd, 16'h0325);
        sel1 = 1'b0; sel2 = 1'b1;
        idle(1);
        check("pause_sel2_lap1", disp_bcd, 16'h0710);
        sel1 = 1'b1;
        idle(1);
        check("pause_both_err", disp_bcd, 16'hBBBB);
        pulse(1, 0, 0);
        idle(1);
        check("run_both_err", disp_bcd, 16'hBBBB);
        sel1 = 1'b0; sel2 = 1'b0;
        idle(1);
        check("run_live_again", disp_bcd, 16'h0720);

        // Async reset mid-run at 05.50
        rst = 1'b1; #2; rst = 1'b0;
        idle(1);
        pulse(1, 0, 0);
        ticks(550);
        idle(1);
        check("pre_rst_disp", disp_bcd, 16'h0550);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk15);
        rst = 1'b0;
        pulse(0, 1, 0);
        check("idle_record_ignored", 16'(lap_cnt), 16'h0);
        pulse(1, 1, 0);
        check("idle_start_rec_running", 16'(running), 16'h1);
        check("idle_start_rec_nolap", 16'(lap_cnt), 16'h0);

        // tick + record at 00.99
        ticks(99);
        pulse(0, 1, 1);
        check("tick_rec_cnt", 16'(lap_cnt), 16'h1);
        idle(1);
        check("tick_rec_live", disp_bcd, 16'h0100);
        pulse(1, 0, 0);
        sel2 = 1'b1;
        idle(1);
        check("unwritten_lap1", disp_bcd, 16'h0000);
        sel2 = 1'b0; sel1 = 1'b1;
        idle(1);
        check("tick_rec_lap0", disp_bcd, 16'h0099);
        sel1 = 1'b0;

        // PAUSE + start + record: records and resumes
        pulse(1, 1, 0);
        check("pause_both_running", 16'(running), 16'h1);
        check("pause_both_cnt", 16'(lap_cnt), 16'h2);
        // RUN + start + record on a full bank: pauses, no record
        pulse(1, 1, 0);
        check("run_both_full_running", 16'(running), 16'h0);
        check("run_both_full_cnt", 16'(lap_cnt), 16'h2);
        sel2 = 1'b1;
        idle(1);
        check("pause_both_lap1", disp_bcd, 16'h0100);
        sel2 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
